// File: rtl/updi_phy_ctrl_if.sv
// Command-side handshake between the UPDI access layer (master) and the
// PHY control sequencer (slave).
interface updi_phy_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic       cmd_ready;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] status;

  modport master (
    output cmd_valid, cmd_type, abort,
    input  cmd_ready, busy, done, status
  );

  modport slave (
    input  cmd_valid, cmd_type, abort,
    output cmd_ready, busy, done, status
  );
endinterface

// File: rtl/updi_phy_ctrl.sv
// UPDI PHY control sequencer: owns phy_rst/ten/ren and runs one link
// transaction (RESET, TX, RX, TX_RX) per accepted command, with guard time
// before receive, abort handling and PHY reset recovery.
// Optional TX/RX timeout supervision: define UPDI_PHY_CTRL_TIMEOUT_EN.
module updi_phy_ctrl #(
  parameter int RST_CYCLES     = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  updi_phy_ctrl_if.slave   cmd,
  output logic             phy_rst,
  output logic             ten,
  output logic             ren,
  input  logic             tend,
  input  logic             rend
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRST, S_TX, S_GUARD, S_RX, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_TX    = 2'b01,
    CMD_RX    = 2'b10,
    CMD_TX_RX = 2'b11
  } cmd_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UPDI_PHY_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_type_q, cmd_type_d;
  logic [1:0]       reason_q, reason_d;
  logic [1:0]       status_q, status_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             ten_q, ten_d;
  logic             ren_q, ren_d;
  logic             prst_q, prst_d;

  logic             rec_go;
  logic [1:0]       rec_why;
  logic             timeout_hit;

  // Terminal count of the TX/RX wait; tied off when supervision is disabled.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == TO_LAST);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_type_d  = cmd_type_q;
    reason_d    = reason_q;
    status_d    = status_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_ready_d = cmd_ready_q;
    ten_d       = ten_q;
    ren_d       = ren_q;
    prst_d      = prst_q;
    rec_go      = 1'b0;
    rec_why     = ST_OK;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          cmd_type_d  = cmd.cmd_type;
          reason_d    = ST_OK;
          unique case (cmd.cmd_type)
            CMD_RESET: begin state_d = S_PRST; prst_d = 1'b1; end
            CMD_RX:    begin state_d = S_RX;   ren_d  = 1'b1; end
            default:   begin state_d = S_TX;   ten_d  = 1'b1; end
          endcase
        end
      end

      S_PRST: begin
        if (cnt_q == RST_LAST) begin
          prst_d   = 1'b0;
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = reason_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_TX: begin
        if (cmd.abort) begin
          rec_go = 1'b1; rec_why = ST_ABORT;
        end else if (tend && ten_q) begin
          ten_d = 1'b0;
          cnt_d = '0;
          if (cmd_type_q == CMD_TX_RX) begin
            if (GUARD_CYCLES == 0) begin
              state_d = S_RX;
              ren_d   = 1'b1;
            end else begin
              state_d = S_GUARD;
            end
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_OK;
          end
        end else if (timeout_hit) begin
          rec_go = 1'b1; rec_why = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GUARD: begin
        if (cmd.abort) begin
          rec_go = 1'b1; rec_why = ST_ABORT;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = S_RX;
          ren_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RX: begin
        if (cmd.abort) begin
          rec_go = 1'b1; rec_why = ST_ABORT;
        end else if (rend && ren_q) begin
          ren_d    = 1'b0;
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          rec_go = 1'b1; rec_why = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort or timeout: release the link lines and run a PHY reset.
    if (rec_go) begin
      ten_d    = 1'b0;
      ren_d    = 1'b0;
      prst_d   = 1'b1;
      reason_d = rec_why;
      cnt_d    = '0;
      state_d  = S_PRST;
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_type_q  <= CMD_RESET;
      reason_q    <= ST_OK;
      status_q    <= ST_OK;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      ten_q       <= 1'b0;
      ren_q       <= 1'b0;
      prst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_type_q  <= cmd_type_d;
      reason_q    <= reason_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      ten_q       <= ten_d;
      ren_q       <= ren_d;
      prst_q      <= prst_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.status    = status_q;
  assign ten           = ten_q;
  assign ren           = ren_q;
  assign phy_rst       = rst | prst_q;

endmodule

// File: tb/tb_updi_phy_ctrl.sv
// Testbench for updi_phy_ctrl: randomized and directed commands, expected
// results from a phase-level reference model pushed into a scoreboard queue,
// and an independent monitor that measures the DUT and compares on done.
`timescale 1ns/1ps
module tb_updi_phy_ctrl;
  localparam int RST_C   = 4;
  localparam int GUARD_C = 16;
  localparam int TO_C    = 100;
  localparam int MAXC    = 10200;
`ifdef UPDI_PHY_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int status; int lat; int ten_n; int ren_n; int prst_n;
  } exp_t;

  typedef struct {
    logic [1:0] typ;
    int tx_ev; int tx_ab; int g_ab; int rx_ev; int rx_ab;
  } plan_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tend = 1'b0;
  logic rend = 1'b0;
  logic phy_rst, ten, ren;

  bit st_tend[MAXC];
  bit st_rend[MAXC];
  bit st_ab[MAXC];
  int ph[MAXC]; // 0 none, 1 TX, 2 GUARD, 3 RX, 4 PRST, 5 DONE

  updi_phy_ctrl_if bus();

  updi_phy_ctrl #(
    .RST_CYCLES(RST_C), .GUARD_CYCLES(GUARD_C), .TIMEOUT_CYCLES(TO_C), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd(bus.slave), .phy_rst(phy_rst),
    .ten(ten), .ren(ren), .tend(tend), .rend(rend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One waiting phase (TX or RX): the first of abort, end strobe or timeout
  // ends it; ties go abort > strobe > timeout.
  task automatic seg(input int ev, input int ab, input bit is_rx, input int t,
                     output int len, output int how);
    len = 32'h3fff_ffff; how = -1;
    if (ab > 0) begin len = ab; how = 1; end
    if (ev > 0 && ev < len) begin len = ev; how = 0; end
    if (TO_EN && TO_C < len) begin len = TO_C; how = 2; end
    if (how < 0) len = 0;
    for (int c = 1; c <= len; c++) ph[t+c] = is_rx ? 3 : 1;
    if (ev > 0 && ev == len) begin
      if (is_rx) st_rend[t+len] = 1'b1; else st_tend[t+len] = 1'b1;
    end
    if (ab > 0 && ab == len) st_ab[t+len] = 1'b1;
  endtask

  // Reference model: builds the per-cycle stimulus for a plan and the
  // expected outcome (status, done cycle, line-high cycle counts).
  task automatic build(input plan_t p, output exp_t e);
    int  t, len, how, why;
    bit  rec, do_rx;
    t = 0; why = 0; rec = 1'b0; do_rx = (p.typ == 2'b10);
    for (int i = 0; i < MAXC; i++) begin
      st_tend[i] = 1'b0; st_rend[i] = 1'b0; st_ab[i] = 1'b0; ph[i] = 0;
    end
    e = '{status: 0, lat: 0, ten_n: 0, ren_n: 0, prst_n: 0};
    if (p.typ == 2'b00) rec = 1'b1;
    if (p.typ == 2'b01 || p.typ == 2'b11) begin
      seg(p.tx_ev, p.tx_ab, 1'b0, t, len, how);
      e.ten_n = len; t += len;
      if (how != 0) begin rec = 1'b1; why = (how == 1) ? 2 : 1; end
      else if (p.typ == 2'b11) begin
        if (p.g_ab > 0 && p.g_ab <= GUARD_C) begin
          for (int c = 1; c <= p.g_ab; c++) ph[t+c] = 2;
          st_ab[t+p.g_ab] = 1'b1; t += p.g_ab; rec = 1'b1; why = 2;
        end else begin
          for (int c = 1; c <= GUARD_C; c++) ph[t+c] = 2;
          t += GUARD_C; do_rx = 1'b1;
        end
      end
    end
    if (do_rx) begin
      seg(p.rx_ev, p.rx_ab, 1'b1, t, len, how);
      e.ren_n = len; t += len;
      if (how != 0) begin rec = 1'b1; why = (how == 1) ? 2 : 1; end
    end
    if (rec) begin
      for (int c = 1; c <= RST_C; c++) ph[t+c] = 4;
      e.prst_n = RST_C; t += RST_C;
    end
    t++; ph[t] = 5; e.lat = t; e.status = why;
    // Strobes/abort in phases where the DUT must ignore them.
    for (int c = 1; c <= t; c++) begin
      if (ph[c] != 1 && $urandom_range(0, 3) == 0) st_tend[c] = 1'b1;
      if (ph[c] != 3 && $urandom_range(0, 3) == 0) st_rend[c] = 1'b1;
      if (ph[c] >= 4 && $urandom_range(0, 2) == 0) st_ab[c]   = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.abort = 1'b0; tend = 1'b0; rend = 1'b0;
  endtask

  int last_wait;

  // Issue one command; returns in its done cycle.
  task automatic run_cmd(input plan_t p, input bit hold_next, input logic [1:0] ntyp);
    exp_t e;
    int   w;
    w = 0;
    build(p, e);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_type = p.typ;
    bus.abort = 1'b0; tend = 1'b0; rend = 1'b0;
    while (bus.cmd_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    last_wait = w;
    check("accept_within_bound", w < 300, 1);
    if (w >= 300) begin bus.cmd_valid = 1'b0; return; end
    exp_q.push_back(e);
    for (int c = 1; c <= e.lat; c++) begin
      @(negedge clk);
      bus.cmd_valid = hold_next;
      bus.cmd_type  = hold_next ? ntyp : 2'b00;
      tend = st_tend[c]; rend = st_rend[c]; bus.abort = st_ab[c];
    end
  endtask

  // Monitor: measures each transaction and compares against the scoreboard.
  initial begin
    bit   active, idle_chk;
    int   lat, tn, rn, pn, last_status;
    exp_t e;
    active = 0; idle_chk = 0; lat = 0; tn = 0; rn = 0; pn = 0; last_status = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        active = 0; idle_chk = 0; last_status = 0;
        continue;
      end
      check("ten_ren_exclusive", ten & ren, 0);
      check("lines_low_in_prst", (ten | ren) & phy_rst, 0);
      if (!bus.done) check("status_held", bus.status, last_status);
      if (active) begin
        lat++; tn += int'(ten); rn += int'(ren); pn += int'(phy_rst);
        check("busy_while_active", bus.busy, 1);
        check("ready_low_while_active", bus.cmd_ready, 0);
        if (bus.done) begin
          check("scoreboard_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("done_status", bus.status, e.status);
            check("done_latency", lat, e.lat);
            check("ten_high_cycles", tn, e.ten_n);
            check("ren_high_cycles", rn, e.ren_n);
            check("phy_rst_high_cycles", pn, e.prst_n);
          end
          last_status = int'(bus.status);
          active = 0; idle_chk = 1;
        end
      end else begin
        check("no_done_when_idle", bus.done, 0);
        if (idle_chk) begin
          check("idle_after_done_busy", bus.busy, 0);
          check("idle_after_done_ready", bus.cmd_ready, 1);
          idle_chk = 0;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          active = 1; lat = 0; tn = 0; rn = 0; pn = 0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'b00; bus.abort = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_phy_rst", phy_rst, 1);
    check("rst_ten", ten, 0);
    check("rst_ren", ren, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_status", bus.status, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_phy_rst", phy_rst, 0);
    check("post_rst_ready", bus.cmd_ready, 1);

    // RESET command.
    p = '{typ: 2'b00, tx_ev: 0, tx_ab: 0, g_ab: 0, rx_ev: 0, rx_ab: 0};
    run_cmd(p, 1'b0, 2'b00);
    // TX_RX with guard time.
    p = '{typ: 2'b11, tx_ev: 10, tx_ab: 0, g_ab: 0, rx_ev: 7, rx_ab: 0};
    run_cmd(p, 1'b0, 2'b00);
    // RX without rend: timeout when supervised, otherwise waits until abort.
    p = '{typ: 2'b10, tx_ev: 0, tx_ab: 0, g_ab: 0, rx_ev: 0, rx_ab: 10001};
    run_cmd(p, 1'b0, 2'b00);
    // TX with abort and tend in the same cycle.
    p = '{typ: 2'b01, tx_ev: 3, tx_ab: 3, g_ab: 0, rx_ev: 0, rx_ab: 0};
    run_cmd(p, 1'b0, 2'b00);
    // TX request held during an RX: accepted only after done.
    p = '{typ: 2'b10, tx_ev: 0, tx_ab: 0, g_ab: 0, rx_ev: 12, rx_ab: 0};
    run_cmd(p, 1'b1, 2'b01);
    p = '{typ: 2'b01, tx_ev: 5, tx_ab: 0, g_ab: 0, rx_ev: 0, rx_ab: 0};
    run_cmd(p, 1'b0, 2'b00);
    check("held_cmd_accepted_after_done", last_wait, 0);
    idle();

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      p.typ   = 2'($urandom_range(0, 3));
      p.tx_ev = $urandom_range(1, 25);
      p.rx_ev = $urandom_range(1, 25);
      p.tx_ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      p.g_ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, GUARD_C + 4) : 0;
      p.rx_ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      if (TO_EN && $urandom_range(0, 5) == 0) p.tx_ev = 0;
      if (TO_EN && $urandom_range(0, 5) == 0) p.rx_ev = 0;
      repeat ($urandom_range(0, 3)) idle();
      run_cmd(p, 1'b0, 2'b00);
    end
    idle();

    // Synchronous reset in the middle of GUARD.
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_type = 2'b11;
    @(negedge clk); bus.cmd_valid = 1'b0;   // cycle 1 (TX)
    @(negedge clk);                         // cycle 2
    @(negedge clk); tend = 1'b1;            // cycle 3
    @(negedge clk); tend = 1'b0;            // cycle 4 (GUARD)
    repeat (3) @(negedge clk);              // cycle 7
    #1;
    check("guard_ten_low", ten, 0);
    check("guard_ren_low", ren, 0);
    check("guard_busy", bus.busy, 1);
    @(negedge clk); rst = 1'b1;             // cycle 8
    @(negedge clk); #1;
    check("midrst_ten", ten, 0);
    check("midrst_ren", ren, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_phy_rst", phy_rst, 1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("after_rst_ready", bus.cmd_ready, 1);
    check("after_rst_phy_rst", phy_rst, 0);
    repeat (30) idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
